// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default operand width and a
// two's-complement magnitude helper used by the signed datapaths.
package alu_pkg;

  localparam int ALU_WIDTH     = 8;
  localparam int ALU_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Caller zero-extends the operand and passes its own sign bit, so the low
  // bits of the result are the exact magnitude for any width up to 32.
  function automatic logic [ALU_MAX_WIDTH-1:0] abs_mag(
    input logic [ALU_MAX_WIDTH-1:0] x,
    input logic                     neg
  );
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/div_step_unit.sv
// One restoring-division iteration: shift {rem, dividend} left, trial-subtract
// the divisor magnitude, then keep or restore the remainder.
module div_step_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] dvd_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             q_bit;

  // Extra top bit on the trial makes a negative difference visible as a borrow.
  always_comb begin
    shifted = {rem_in, dvd_in[WIDTH-1]};
    trial   = shifted - {2'b00, dvs};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    dvd_out = {dvd_in[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_REMAINDER_EN to expose the signed remainder output.
module seq_divider
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               sign_flag,
  output logic               zero_flag,
  output logic               div_zero
`ifdef SEQ_DIVIDER_REMAINDER_EN
  ,
  output logic [WIDTH-1:0]   remainder
`endif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_FIX  = FIX;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sign_quo_q, sign_quo_d;
  logic               bzero_q, bzero_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               sign_flag_q, sign_flag_d;
  logic               zero_flag_q, zero_flag_d;
  logic               div_zero_q, div_zero_d;
`ifdef SEQ_DIVIDER_REMAINDER_EN
  logic               sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic [WIDTH-1:0]   rem_fix;
`endif

  logic [ALU_MAX_WIDTH-1:0] a_abs;
  logic [ALU_MAX_WIDTH-1:0] b_abs;
  logic [WIDTH-1:0]         a_mag;
  logic [WIDTH-1:0]         b_mag;
  logic                     unused_abs_hi;
  logic [WIDTH:0]           step_rem;
  logic [WIDTH-1:0]         step_dvd;
  logic [2*WIDTH-1:0]       quo_ext;
  logic [2*WIDTH-1:0]       quo_signed;

  assign a_abs         = abs_mag(ALU_MAX_WIDTH'(a), a[WIDTH-1]);
  assign b_abs         = abs_mag(ALU_MAX_WIDTH'(b), b[WIDTH-1]);
  assign a_mag         = a_abs[WIDTH-1:0];
  assign b_mag         = b_abs[WIDTH-1:0];
  assign unused_abs_hi = ^{a_abs, b_abs};

  div_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .dvd_in  (dvd_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .dvd_out (step_dvd)
  );

  // The dividend register is shifted out as the quotient fills in from the LSB.
  assign quo_ext    = {{WIDTH{1'b0}}, dvd_q};
  assign quo_signed = sign_quo_q ? -quo_ext : quo_ext;

`ifdef SEQ_DIVIDER_REMAINDER_EN
  // With no iterations run, dvd_q still holds |a|, so sign_r restores a itself.
  assign rem_fix = bzero_q ? dvd_q : rem_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    count_d     = count_q;
    sign_quo_d  = sign_quo_q;
    bzero_d     = bzero_q;
    result_d    = result_q;
    sign_flag_d = sign_flag_q;
    zero_flag_d = zero_flag_q;
    div_zero_d  = div_zero_q;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    sign_rem_d  = sign_rem_q;
    remainder_d = remainder_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d      = '0;
          dvd_d      = a_mag;
          dvs_d      = b_mag;
          count_d    = CNT_W'(WIDTH);
          sign_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          bzero_d    = (b == '0);
`ifdef SEQ_DIVIDER_REMAINDER_EN
          sign_rem_d = a[WIDTH-1];
`endif
          state_d    = (b == '0) ? ST_FIX : ST_RUN;
        end
      end

      ST_RUN: begin
        rem_d   = step_rem;
        dvd_d   = step_dvd;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        result_d    = bzero_q ? '0 : quo_signed;
        sign_flag_d = result_d[2*WIDTH-1];
        zero_flag_d = (result_d == '0);
        div_zero_d  = bzero_q;
`ifdef SEQ_DIVIDER_REMAINDER_EN
        remainder_d = sign_rem_q ? -rem_fix : rem_fix;
`endif
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      count_q     <= '0;
      sign_quo_q  <= 1'b0;
      bzero_q     <= 1'b0;
      result_q    <= '0;
      sign_flag_q <= 1'b0;
      zero_flag_q <= 1'b1;
      div_zero_q  <= 1'b0;
`ifdef SEQ_DIVIDER_REMAINDER_EN
      sign_rem_q  <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      count_q     <= count_d;
      sign_quo_q  <= sign_quo_d;
      bzero_q     <= bzero_d;
      result_q    <= result_d;
      sign_flag_q <= sign_flag_d;
      zero_flag_q <= zero_flag_d;
      div_zero_q  <= div_zero_d;
`ifdef SEQ_DIVIDER_REMAINDER_EN
      sign_rem_q  <= sign_rem_d;
      remainder_q <= remainder_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign sign_flag = sign_flag_q;
  assign zero_flag = zero_flag_q;
  assign div_zero  = div_zero_q;
`ifdef SEQ_DIVIDER_REMAINDER_EN
  assign remainder = remainder_q;
`endif

endmodule
